buzzer_tone_gen: RTL and testbench
==================================

// Module: buzzer_tone_gen
// PURPOSE
//  Downstream of the auto-play sequencer. Converts the 4-bit note code it emits
//  (0 = rest, 1..7 = do..si, 15 = end marker) into a square wave for the buzzer.
//  Inserts a short silent gap whenever the note changes, so consecutive notes
//  articulate instead of slurring.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency; all divisors derive from it
//  GAP_CYCLES  2_000_000    silent cycles inserted on note change (0 = no gap)
//  CNT_W       20           half-period/gap counter width; must hold 2*max half-period
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  note_in     in   4  note code from sequencer, sampled every cycle
//  octave_in   in   2  0 = low (x2 period), 1 = mid, 2 = high (/2 period), 3 = mid
//  mute        in   1  1 = force speaker low; FSM and counters keep running
//  speaker     out  1  square-wave drive to buzzer, registered
//  playing     out  1  1 while FSM is in PLAY
// BEHAVIOUR
//  Reset (reset=0, async): state=SILENT, note_q=0, oct_q=1, cnt=0, phase=0,
//  speaker=0, playing=0.
//  Input sampling: note_q/oct_q register note_in/octave_in each cycle.
//  change = ({note_q,oct_q} != previous registered value).
//  Decode: codes 1..7 are tones; 0 and 8..15 are rests.
//  Mid-octave half-period = floor(CLK_HZ / (2*f)), f = 262,294,330,349,392,440,494 Hz.
//  Low octave shifts left by 1; high octave shifts right by 1. All arithmetic
//  unsigned, CNT_W bits.
//  FSM states: SILENT, GAP, PLAY.
//   - Any state, change=1 -> GAP if GAP_CYCLES>0, else straight to target;
//     cnt=0, phase=0. Change takes priority over every other event in that cycle.
//   - GAP: cnt counts up; at cnt==GAP_CYCLES-1 go to PLAY (tone) or SILENT (rest), cnt=0.
//   - PLAY: cnt counts up; at cnt==half-1, toggle phase and set cnt=0.
//   - SILENT: cnt=0, phase=0.
//   - A change during GAP restarts the gap from 0.
//  First speaker rising edge: half cycles after entering PLAY, plus 1 cycle output register.
//  speaker <= phase & (state==PLAY) & ~mute. Registered, so 1 cycle of latency.
//  playing <= (next state == PLAY).
//  End marker 15 is treated as a rest: speaker stays low until the next tone code.
//  Same code held for many cycles: no re-articulation. The tone continues phase-continuous.
// STRUCTURE
//  Shared header music_defs.vh: note codes (REST=0, DO..SI=1..7, END=15),
//  note frequencies, octave encodings, FSM state encodings.
//  Sub-module note_period_lut: combinational (note_q, oct_q, CLK_HZ) -> half-period
//  (CNT_W bits, 0 for rest codes).
//  Top module holds the input registers, FSM, counter and output register.
// TESTING  (bench overrides CLK_HZ=1_000_000, GAP_CYCLES=10)
//  1. Reset held, then release with note_in=0 -> speaker=0, playing=0 for 5000 cycles.
//  2. note_in=6, octave=1 -> 10 cycles of gap, then playing=1; speaker half-period
//     = 1136 cycles (period 2272).
//  3. note_in=1, octave 0/1/2 -> half-period 3816 / 1908 / 954 cycles respectively.
//  4. 6 -> 7 while playing -> speaker drops low within 2 cycles, stays low 10 cycles,
//     then half-period 1012.
//  5. note_in=15 after a tone -> gap, then SILENT; speaker=0 and playing=0 indefinitely.
//  6. mute=1 mid-tone for 3000 cycles, then 0 -> speaker low while muted; on release
//     phase is unbroken (edges stay on the 1136 grid). Also: reset=0 mid-tone ->
//     speaker=0 immediately (async).

Source files
------------

// File: rtl/buzzer_tone_gen_pkg.sv
// Shared definitions for the buzzer tone generator: note codes, octave codes,
// note frequencies and FSM state encoding.
package buzzer_tone_gen_pkg;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_GAP    = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SO   = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;

  localparam int FREQ_DO = 262;
  localparam int FREQ_RE = 294;
  localparam int FREQ_MI = 330;
  localparam int FREQ_FA = 349;
  localparam int FREQ_SO = 392;
  localparam int FREQ_LA = 440;
  localparam int FREQ_SI = 494;

  // Mid-octave half-period in clock cycles; evaluated only at elaboration.
  function automatic int mid_half(input int clk_hz, input int freq);
    return clk_hz / (2 * freq);
  endfunction

endpackage

// File: rtl/buzzer_tone_gen_lut.sv
// Combinational note/octave to half-period lookup. Rest codes (0, 8..15)
// return zero; octave 0 doubles the period, octave 2 halves it.
module note_period_lut
  import buzzer_tone_gen_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 20
) (
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  output logic [CNT_W-1:0] half
);

  localparam logic [CNT_W-1:0] H_DO = CNT_W'(mid_half(CLK_HZ, FREQ_DO));
  localparam logic [CNT_W-1:0] H_RE = CNT_W'(mid_half(CLK_HZ, FREQ_RE));
  localparam logic [CNT_W-1:0] H_MI = CNT_W'(mid_half(CLK_HZ, FREQ_MI));
  localparam logic [CNT_W-1:0] H_FA = CNT_W'(mid_half(CLK_HZ, FREQ_FA));
  localparam logic [CNT_W-1:0] H_SO = CNT_W'(mid_half(CLK_HZ, FREQ_SO));
  localparam logic [CNT_W-1:0] H_LA = CNT_W'(mid_half(CLK_HZ, FREQ_LA));
  localparam logic [CNT_W-1:0] H_SI = CNT_W'(mid_half(CLK_HZ, FREQ_SI));

  logic [CNT_W-1:0] mid;

  always_comb begin
    mid  = '0;
    half = '0;
    case (note)
      NOTE_DO: mid = H_DO;
      NOTE_RE: mid = H_RE;
      NOTE_MI: mid = H_MI;
      NOTE_FA: mid = H_FA;
      NOTE_SO: mid = H_SO;
      NOTE_LA: mid = H_LA;
      NOTE_SI: mid = H_SI;
      default: mid = '0;
    endcase
    case (octave)
      OCT_LOW:  half = mid << 1;
      OCT_HIGH: half = mid >> 1;
      default:  half = mid;
    endcase
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: registers the sequencer's note code, inserts a
// silent gap on every note change, then toggles the speaker every half-period.
module buzzer_tone_gen
  import buzzer_tone_gen_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int GAP_CYCLES = 2_000_000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  input  logic       mute,
  output logic       speaker,
  output logic       playing
);

  // The shared counter is widened when the gap needs more bits than a half-period.
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int CW    = (GAP_W > CNT_W) ? GAP_W : CNT_W;
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d, target;
  logic [3:0]       note_q;
  logic [1:0]       oct_q;
  logic [5:0]       prev_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             change;
  logic [CNT_W-1:0] half;
  logic [CW-1:0]    half_x;

  note_period_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .note   (note_q),
    .octave (oct_q),
    .half   (half)
  );

  assign half_x = CW'(half);
  assign change = ({note_q, oct_q} != prev_q);
  assign target = (half != '0) ? ST_PLAY : ST_SILENT;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (change) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      state_d = (GAP_CYCLES > 0) ? ST_GAP : target;
    end else begin
      case (state_q)
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = target;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_PLAY: begin
          if (cnt_q == half_x - CW'(1)) begin
            phase_d = ~phase_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      endcase
    end
  end

  // Input capture, FSM state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SILENT;
      note_q  <= NOTE_REST;
      oct_q   <= OCT_MID;
      prev_q  <= {NOTE_REST, OCT_MID};
      cnt_q   <= '0;
      phase_q <= 1'b0;
      speaker <= 1'b0;
      playing <= 1'b0;
    end else begin
      note_q  <= note_in;
      oct_q   <= octave_in;
      prev_q  <= {note_q, oct_q};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      speaker <= phase_q & (state_q == ST_PLAY) & ~mute;
      playing <= (state_d == ST_PLAY);
    end
  end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Self-checking bench for buzzer_tone_gen: elapsed-time reference model checked
// every cycle, directed literal timing checks, then randomized note sequences.
module tb_buzzer_tone_gen;

  localparam int CLK_HZ = 1_000_000;
  localparam int GAP    = 10;
  localparam int CNT_W  = 20;
  localparam int JMAX   = 1 << 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic [1:0] octave_in = 2'd1;
  logic       mute = 1'b0;
  logic       speaker, playing;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  buzzer_tone_gen #(
    .CLK_HZ     (CLK_HZ),
    .GAP_CYCLES (GAP),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .note_in   (note_in),
    .octave_in (octave_in),
    .mute      (mute),
    .speaker   (speaker),
    .playing   (playing)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference: half-period straight from the frequency table and octave rule.
  function automatic int half_of(input logic [5:0] code);
    int f, h;
    case (code[5:2])
      4'd1: f = 262;
      4'd2: f = 294;
      4'd3: f = 330;
      4'd4: f = 349;
      4'd5: f = 392;
      4'd6: f = 440;
      4'd7: f = 494;
      default: f = 0;
    endcase
    if (f == 0) return 0;
    h = CLK_HZ / (2 * f);
    if (code[1:0] == 2'd0) h = h * 2;
    else if (code[1:0] == 2'd2) h = h / 2;
    return h;
  endfunction

  // Tone audible once the gap has elapsed since the last articulation.
  function automatic bit m_play(input logic [5:0] code, input int j);
    return (half_of(code) != 0) && (j >= GAP);
  endfunction

  function automatic bit m_phase(input logic [5:0] code, input int j);
    if (!m_play(code, j)) return 1'b0;
    return (((j - GAP) / half_of(code)) % 2) == 1;
  endfunction

  // Model: code seen by the design, code one cycle earlier, current segment
  // code and elapsed cycles since that segment's articulation began.
  logic [5:0] mq = 6'h01, mprev = 6'h01, seg = 6'h01;
  int         j = JMAX;
  logic       exp_spk = 1'b0, exp_ply = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq = 6'h01; mprev = 6'h01; seg = 6'h01; j = JMAX;
      exp_spk = 1'b0; exp_ply = 1'b0;
    end else begin
      cyc++;
      exp_spk = m_play(seg, j) && m_phase(seg, j) && !mute;
      if (mq != mprev) begin
        seg = mq;
        j = 0;
      end else if (j < JMAX) begin
        j++;
      end
      mprev = mq;
      mq = {note_in, octave_in};
      exp_ply = m_play(seg, j);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("speaker_cycle", {31'd0, speaker}, {31'd0, exp_spk});
      check("playing_cycle", {31'd0, playing}, {31'd0, exp_ply});
    end
  end

  // Wait (bounded) until speaker (sel=0) or playing (sel=1) equals val.
  task automatic wait_for(input bit sel, input logic val, input int maxc,
                          input string nm, output int n);
    n = 0;
    while (((sel ? playing : speaker) !== val) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if ((sel ? playing : speaker) !== val) begin
      checks++;
      failures++;
      $display("FAIL %s timeout after %0d cycles waiting for %0d", nm, n, val);
    end
  endtask

  task automatic run_len(input logic val, input int maxc, output int n);
    n = 0;
    while (speaker === val && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic half_check(input string nm, input int exp);
    int n;
    wait_for(1'b0, 1'b1, 3 * exp + 50, nm, n);
    run_len(1'b1, 2 * exp + 10, n);
    check({nm, "_high"}, n, exp);
    run_len(1'b0, 2 * exp + 10, n);
    check({nm, "_low"}, n, exp);
  endtask

  task automatic set_note(input logic [3:0] n, input logic [1:0] o);
    @(negedge clk);
    note_in = n;
    octave_in = o;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t1, t2, hold;

    // Reset, then long idle with a rest code
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_speaker", {31'd0, speaker}, 32'd0);
    check("reset_playing", {31'd0, playing}, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (5000) @(negedge clk);
    check("idle_speaker", {31'd0, speaker}, 32'd0);
    check("idle_playing", {31'd0, playing}, 32'd0);

    // LA mid: gap latency then 1136-cycle half-period
    set_note(4'd6, 2'd1);
    wait_for(1'b1, 1'b1, 100, "gap_to_play", n);
    check("gap_to_play", n, 12);
    half_check("la_mid", 1136);

    // DO in each octave
    set_note(4'd1, 2'd0);
    repeat (3) @(negedge clk);
    half_check("do_low", 3816);
    set_note(4'd1, 2'd1);
    repeat (3) @(negedge clk);
    half_check("do_mid", 1908);
    set_note(4'd1, 2'd2);
    repeat (3) @(negedge clk);
    half_check("do_high", 954);

    // LA -> SI while the speaker is high
    set_note(4'd6, 2'd1);
    repeat (3) @(negedge clk);
    wait_for(1'b0, 1'b1, 3000, "la_rise", n);
    note_in = 4'd7;
    repeat (3) @(negedge clk);
    check("si_drop_low", {31'd0, speaker}, 32'd0);
    run_len(1'b0, 3000, n);
    check("si_gap_then_rise", n, 1022);
    run_len(1'b1, 3000, n);
    check("si_half_high", n, 1012);

    // End marker behaves as a rest
    set_note(4'd15, 2'd1);
    repeat (3000) @(negedge clk);
    check("end_speaker", {31'd0, speaker}, 32'd0);
    check("end_playing", {31'd0, playing}, 32'd0);

    // Mute mid-tone keeps the phase grid
    set_note(4'd6, 2'd1);
    wait_for(1'b0, 1'b1, 2000, "mute_first_rise", n);
    t1 = cyc;
    repeat (500) @(negedge clk);
    mute = 1'b1;
    repeat (3000) @(negedge clk);
    check("muted_speaker", {31'd0, speaker}, 32'd0);
    mute = 1'b0;
    wait_for(1'b0, 1'b0, 3000, "unmute_low", n);
    wait_for(1'b0, 1'b1, 3000, "unmute_rise", n);
    t2 = cyc;
    check("mute_phase_grid", (t2 - t1) % 2272, 0);

    // Asynchronous reset mid-tone
    wait_for(1'b0, 1'b1, 3000, "async_pre_rise", n);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_speaker", {31'd0, speaker}, 32'd0);
    check("async_reset_playing", {31'd0, playing}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized note/octave/mute sequences, including short holds
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      note_in = 4'($urandom_range(0, 15));
      octave_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) mute = ~mute;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(20, 2000);
      repeat (hold) @(negedge clk);
    end
    mute = 1'b0;
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
